// File: rtl/serial_frame_tx_pkg.sv
// Shared types and helpers for the framed serial transmitter.
package serial_frame_tx_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } tx_state_t;

   // Counter width that stays at least one bit wide for degenerate counts.
   function automatic int min1_clog2(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/serial_frame_tx_piso_shifter.sv
// Parallel-load shift register feeding the transmitter one bit at a time.
module tx_piso_shifter #(
   parameter int WIDTH     = 8,
   parameter int LSB_FIRST = 1
) (
   input  logic             clock,
   input  logic             preset_L,
   input  logic             load,
   input  logic             shift,
   input  logic [WIDTH-1:0] load_data,
   output logic             out_bit
);

   logic [WIDTH-1:0] sr_q;
   logic [WIDTH-1:0] sr_d;

   always_comb begin
      sr_d = sr_q;
      if (load) begin
         sr_d = load_data;
      end else if (shift) begin
         if (LSB_FIRST != 0) sr_d = {1'b0, sr_q[WIDTH-1:1]};
         else                sr_d = {sr_q[WIDTH-2:0], 1'b0};
      end
   end

   always_ff @(posedge clock or negedge preset_L) begin
      if (!preset_L) sr_q <= '0;
      else           sr_q <= sr_d;
   end

   assign out_bit = (LSB_FIRST != 0) ? sr_q[0] : sr_q[WIDTH-1];

endmodule

// File: rtl/serial_frame_tx.sv
// Framed serial transmitter: start bit, data bits, optional even parity, stop bit.
// Handshake: a word is taken on any posedge where valid and ready are both high.
module serial_frame_tx
   import serial_frame_tx_pkg::*;
#(
   parameter int WIDTH        = 8,
   parameter int CLKS_PER_BIT = 4,
   parameter int PARITY_EN    = 1,
   parameter int LSB_FIRST    = 1
) (
   input  logic             clock,
   input  logic             preset_L,
   input  logic [WIDTH-1:0] data,
   input  logic             valid,
   output logic             ready,
   output logic             serial_out,
   output logic             busy,
   output logic             done
);

   localparam int TW = min1_clog2(CLKS_PER_BIT);
   localparam int IW = min1_clog2(WIDTH);
   localparam logic [TW-1:0] T_LAST = TW'(CLKS_PER_BIT - 1);
   localparam logic [IW-1:0] I_LAST = IW'(WIDTH - 1);

   tx_state_t     state_q, state_d;
   logic [TW-1:0] timer_q, timer_d;
   logic [IW-1:0] idx_q, idx_d;
   logic          parity_q, parity_d;
   logic          serial_q, serial_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic          load, shift, shift_bit, slot_end;

   assign slot_end = (timer_q == T_LAST);

   tx_piso_shifter #(
      .WIDTH     (WIDTH),
      .LSB_FIRST (LSB_FIRST)
   ) u_shifter (
      .clock     (clock),
      .preset_L  (preset_L),
      .load      (load),
      .shift     (shift),
      .load_data (data),
      .out_bit   (shift_bit)
   );

   always_comb begin
      state_d  = state_q;
      timer_d  = timer_q;
      idx_d    = idx_q;
      parity_d = parity_q;
      serial_d = serial_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      load     = 1'b0;
      shift    = 1'b0;

      if (state_q != IDLE) timer_d = slot_end ? '0 : timer_q + TW'(1);

      case (state_q)
         IDLE: begin
            serial_d = 1'b1;
            if (valid) begin
               load     = 1'b1;
               parity_d = ^data;
               state_d  = START;
               serial_d = 1'b0;
               busy_d   = 1'b1;
               idx_d    = '0;
               timer_d  = '0;
            end
         end
         START: begin
            if (slot_end) begin
               // Present the current head bit and advance the shifter in the same edge.
               state_d  = DATA;
               serial_d = shift_bit;
               shift    = 1'b1;
            end
         end
         DATA: begin
            if (slot_end) begin
               if (idx_q == I_LAST) begin
                  idx_d = '0;
                  if (PARITY_EN != 0) begin
                     state_d  = PARITY;
                     serial_d = parity_q;
                  end else begin
                     state_d  = STOP;
                     serial_d = 1'b1;
                  end
               end else begin
                  idx_d    = idx_q + IW'(1);
                  serial_d = shift_bit;
                  shift    = 1'b1;
               end
            end
         end
         PARITY: begin
            if (slot_end) begin
               state_d  = STOP;
               serial_d = 1'b1;
            end
         end
         STOP: begin
            if (slot_end) begin
               state_d  = IDLE;
               serial_d = 1'b1;
               busy_d   = 1'b0;
               done_d   = 1'b1;
            end
         end
         default: begin
            state_d  = IDLE;
            serial_d = 1'b1;
            busy_d   = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clock or negedge preset_L) begin
      if (!preset_L) begin
         state_q  <= IDLE;
         timer_q  <= '0;
         idx_q    <= '0;
         parity_q <= 1'b0;
         serial_q <= 1'b1;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         timer_q  <= timer_d;
         idx_q    <= idx_d;
         parity_q <= parity_d;
         serial_q <= serial_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

   assign ready      = (state_q == IDLE);
   assign serial_out = serial_q;
   assign busy       = busy_q;
   assign done       = done_q;

endmodule

// File: tb/tb_serial_frame_tx.sv
// Directed bench for serial_frame_tx: default build plus a 1-clock-per-bit MSB-first build.
module tb_serial_frame_tx;

   logic       clock = 1'b0;
   logic       preset_L = 1'b1;
   logic [7:0] data, data6;
   logic       valid, valid6;
   logic       ready, serial_out, busy, done;
   logic       ready6, serial_out6, busy6, done6;

   int checks = 0;
   int errors = 0;

   always #5 clock = ~clock;

   serial_frame_tx u_dut (
      .clock      (clock),
      .preset_L   (preset_L),
      .data       (data),
      .valid      (valid),
      .ready      (ready),
      .serial_out (serial_out),
      .busy       (busy),
      .done       (done)
   );

   serial_frame_tx #(
      .WIDTH        (8),
      .CLKS_PER_BIT (1),
      .PARITY_EN    (0),
      .LSB_FIRST    (0)
   ) u_dut6 (
      .clock      (clock),
      .preset_L   (preset_L),
      .data       (data6),
      .valid      (valid6),
      .ready      (ready6),
      .serial_out (serial_out6),
      .busy       (busy6),
      .done       (done6)
   );

   // Frame bits indexed by slot: [0]=start, [8:1]=data in send order, [9]=parity, [10]=stop.
   typedef struct {
      logic [7:0]  data;
      logic [10:0] frame;
   } vec_t;

   vec_t vecs[4];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic wait_ready();
      for (int i = 0; i < 200; i++) begin
         if (ready) break;
         @(negedge clock);
      end
      chk("ready_wait", ready, 1);
   endtask

   // Entered just after the accept edge; checks every clock of the frame and the done clock.
   task automatic check_frame(input string name, input logic [10:0] frame, input bit disturb);
      for (int k = 0; k < 44; k++) begin
         @(negedge clock);
         if (disturb) begin
            data  = 8'h00;
            valid = k[0];
         end
         chk($sformatf("%s_bit%0d", name, k), serial_out, frame[k/4]);
         chk($sformatf("%s_busy", name), busy, 1);
         chk($sformatf("%s_ready", name), ready, 0);
         chk($sformatf("%s_done", name), done, 0);
      end
      @(negedge clock);
      if (disturb) valid = 1'b0;
      chk($sformatf("%s_done_pulse", name), done, 1);
      chk($sformatf("%s_done_ready", name), ready, 1);
      chk($sformatf("%s_done_busy", name), busy, 0);
      chk($sformatf("%s_done_line", name), serial_out, 1);
   endtask

   task automatic send_frame(input string name, input logic [7:0] d, input logic [10:0] frame,
                             input bit disturb);
      wait_ready();
      data  = d;
      valid = 1'b1;
      @(posedge clock);
      #1 valid = 1'b0;
      check_frame(name, frame, disturb);
      @(negedge clock);
      chk($sformatf("%s_done_drop", name), done, 0);
      chk($sformatf("%s_idle_ready", name), ready, 1);
      chk($sformatf("%s_idle_busy", name), busy, 0);
      chk($sformatf("%s_idle_line", name), serial_out, 1);
   endtask

   initial begin
      logic [9:0] f6;
      data   = 8'h00;
      valid  = 1'b0;
      data6  = 8'h00;
      valid6 = 1'b0;

      vecs[0] = '{data: 8'hA5, frame: 11'b1_0_10100101_0};
      vecs[1] = '{data: 8'h07, frame: 11'b1_1_00000111_0};
      vecs[2] = '{data: 8'h00, frame: 11'b1_0_00000000_0};
      vecs[3] = '{data: 8'hFF, frame: 11'b1_0_11111111_0};

      // Reset behaviour.
      #2 preset_L = 1'b0;
      #1;
      chk("rst_line", serial_out, 1);
      chk("rst_ready", ready, 1);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst6_line", serial_out6, 1);
      chk("rst6_ready", ready6, 1);
      repeat (2) @(negedge clock);
      preset_L = 1'b1;
      repeat (3) @(negedge clock);
      chk("idle_line", serial_out, 1);
      chk("idle_ready", ready, 1);
      chk("idle_done", done, 0);

      // Table-driven single frames.
      foreach (vecs[i]) send_frame($sformatf("vec%0d", i), vecs[i].data, vecs[i].frame, 1'b0);

      // Back-to-back: valid held high, second word queued right after the first accept.
      wait_ready();
      data  = 8'h01;
      valid = 1'b1;
      @(posedge clock);
      #1 data = 8'hFF;
      check_frame("b2b1", 11'b1_1_00000001_0, 1'b0);
      @(posedge clock);
      #1 valid = 1'b0;
      check_frame("b2b2", 11'b1_0_11111111_0, 1'b0);
      @(negedge clock);
      chk("b2b_done_drop", done, 0);

      // Reset in the middle of data bit 3 of an 8'h3C frame.
      wait_ready();
      data  = 8'h3C;
      valid = 1'b1;
      @(posedge clock);
      #1 valid = 1'b0;
      repeat (18) @(negedge clock);
      chk("abort_pre_bit3", serial_out, 1);
      chk("abort_pre_busy", busy, 1);
      #1 preset_L = 1'b0;
      #1;
      chk("abort_line", serial_out, 1);
      chk("abort_ready", ready, 1);
      chk("abort_busy", busy, 0);
      chk("abort_done", done, 0);
      @(negedge clock);
      preset_L = 1'b1;
      for (int k = 0; k < 50; k++) begin
         @(negedge clock);
         chk("abort_no_done", done, 0);
      end
      send_frame("after_abort", 8'h3C, 11'b1_0_00111100_0, 1'b0);

      // Inputs disturbed during an 8'hF0 frame.
      send_frame("ignore", 8'hF0, 11'b1_0_11110000_0, 1'b1);
      @(negedge clock);
      chk("ignore_no_accept", ready, 1);

      // One clock per bit, no parity, MSB first.
      f6 = 10'b1_00000001_0;
      data6  = 8'h80;
      valid6 = 1'b1;
      @(posedge clock);
      #1 valid6 = 1'b0;
      for (int k = 0; k < 10; k++) begin
         @(negedge clock);
         chk($sformatf("msb_bit%0d", k), serial_out6, f6[k]);
         chk("msb_busy", busy6, 1);
         chk("msb_done", done6, 0);
      end
      @(negedge clock);
      chk("msb_done_pulse", done6, 1);
      chk("msb_done_ready", ready6, 1);
      chk("msb_done_line", serial_out6, 1);
      @(negedge clock);
      chk("msb_done_drop", done6, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL timeout: simulation did not reach the end");
      $fatal(1, "timeout");
   end

endmodule
